nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Sequencer that drives the `nco` control inputs (`En`, `FCW`, `selXY`, `selSign`) to run a stepped frequency sweep. It dwells on each frequency for a programmed number of NCO output samples and blanks the samples still in flight through the CORDIC pipeline after each FCW change. The block sits directly in front of the `nco` instance. It exports a qualified sample-valid and a segment index, so downstream logic sees only settled samples.

## Interface
- `FCW_W`, 20: FCW width; matches the `nco` FCW port.
- `NUM_W`, 10: width of the step count and segment index.
- `DWELL_W`, 16: width of the dwell sample count.
- `PIPE_DEPTH`, 10: cycles from an FCW change to its first effect on `nco` Dout (phase accumulator + 8 CORDIC stages + output terminal).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Start` in 1: one-cycle pulse; starts a sweep. Accepted only in IDLE.
- `Abort` in 1: one-cycle pulse; ends a sweep immediately.
- `CfgFcw0` in FCW_W: first-segment FCW.
- `CfgStep` in FCW_W: FCW increment per segment, two's complement.
- `CfgNum` in NUM_W: number of segments; 0 is treated as 1.
- `CfgDwell` in DWELL_W: qualified samples per segment; 0 is treated as 1.
- `CfgSelXY`, `CfgSelSign` in 1: output selection applied for the whole sweep.
- `NcoVld` in 1: `nco` Vld output.
- `En` out 1: to `nco` En.
- `FCW` out FCW_W: to `nco` FCW.
- `selXY`, `selSign` out 1: to `nco`.
- `Busy` out 1: high while a sweep is active.
- `Done` out 1: one-cycle pulse when a sweep completes normally.
- `SegVld` out 1: NcoVld qualified to the settled dwell window.
- `SegIdx` out NUM_W: current segment index, starting at 0.

## Operation
- States: IDLE, FLUSH, DWELL, DONE.
- IDLE
  - `En`=0, `Busy`=0.
  - On `Start`: latch all Cfg* inputs into shadow registers, then set `FCW`←CfgFcw0, `SegIdx`←0, flush counter←PIPE_DEPTH−1, and go to FLUSH.
  - Cfg* inputs are don't-care after `Start` is accepted.
- FLUSH
  - `En`=1, `Busy`=1, `SegVld`=0.
  - Counter decrements every cycle. At 0, clear the dwell counter and go to DWELL.
- DWELL
  - `En`=1. `SegVld`=`NcoVld`. Each `NcoVld` increments the dwell counter.
  - On the cycle of the CfgDwell-th `NcoVld`:
    - If `SegIdx`==CfgNum−1, go to DONE.
    - Otherwise `FCW`←`FCW`+CfgStep (mod 2^FCW_W, wrap, no saturation), `SegIdx`++, and go to FLUSH with the counter reloaded.
- DONE
  - `Done`=1, `En`=0, `Busy`=0. Next state is IDLE.
- Abort
  - In FLUSH or DWELL: next state is IDLE, `En`=0, `SegVld`=0, no `Done`.
  - `FCW` and `SegIdx` hold their last values.
  - Has no effect in IDLE or DONE.
- Simultaneous events
  - `Start`+`Abort` in IDLE: Abort wins and the sweep does not start.
  - `Start` while Busy: ignored.
- `selXY`/`selSign` update only when `Start` is accepted and hold afterwards.

## Timing
- Reset (checked at a clock edge) forces: state IDLE; `En`, `FCW`, `selXY`, `selSign`, `Busy`, `Done`, `SegVld`, `SegIdx` all 0.
- Start accepted at edge t:
  - From t+1: `Busy`=1, `En`=1, `FCW`=CfgFcw0.
  - FLUSH occupies t+1 … t+PIPE_DEPTH.
  - DWELL begins at t+PIPE_DEPTH+1.
- Segment end at cycle s (the final `SegVld` is high in s):
  - Next segment: new `FCW` and `SegIdx` are visible at s+1, with `SegVld`=0 for the next PIPE_DEPTH cycles.
  - Last segment: `Done`=1 and `En`=0 at s+1; `Busy`=0 at s+1.
- All outputs are registered. There is no combinational path from input to output except `SegVld`, which is `NcoVld` gated by a registered state bit.
- Reset mid-sweep: IDLE on the next cycle, with the reset values above. No `Done`.

## Structure
- Package `nco_pkg`: FCW_W, PIPE_DEPTH, NUM_W, DWELL_W defaults, and the state enum `sweep_state_t` {IDLE, FLUSH, DWELL, DONE}.
- Single module. No sub-module is needed.
- The top-level wrapper instantiates `nco_sweep_ctrl` and `nco` side by side, with `NcoVld` driven from `nco` Vld.

## Test plan
- Reset check: drive `rst` for 2 cycles mid-sweep → all outputs 0, IDLE next cycle, no `Done`.
- Basic sweep: CfgFcw0=0x01000, CfgStep=0x00800, CfgNum=3, CfgDwell=4, NcoVld always 1.
  - `FCW` sequence 0x01000 → 0x01800 → 0x02000.
  - Per segment: 10 blanked cycles, then 4 `SegVld`.
  - `Done` pulses once, 3·(10+4)+1 cycles after `Start`.
- Wrap and negative step: CfgFcw0=0xFFC00, CfgStep=0x00800, CfgNum=2 → second `FCW`=0x00400. Repeat with CfgStep=0xFF800 from 0x00400 → 0xFFC00.
- Sparse valid: NcoVld high every 3rd cycle, CfgDwell=5 → each DWELL lasts until the 5th pulse (≈15 cycles), and `SegVld` matches `NcoVld` exactly.
- Abort in DWELL of segment 1:
  - `En`=0 and `Busy`=0 next cycle, no `Done`, `SegIdx` holds 1.
  - A new `Start` two cycles later restarts from CfgFcw0 with `SegIdx`=0.
- Zero configs and Start collisions:
  - CfgNum=0 and CfgDwell=0 → one segment with one sample.
  - `Start`+`Abort` in IDLE → no sweep.
  - `Start` while Busy → ignored.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller.
//   - Default widths for the FCW, the segment index and the dwell count.
//   - PIPE_DEPTH: cycles from an FCW change until it first shows up on the
//     nco Dout (phase accumulator + 8 CORDIC stages + output register).
//   - sweep_state_t: sequencer states.
package nco_pkg;

    localparam int FCW_W      = 20;
    localparam int NUM_W      = 10;
    localparam int DWELL_W    = 16;
    localparam int PIPE_DEPTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer placed in front of an nco instance.
// It holds each frequency for a programmed number of valid NCO samples.
// After every FCW change it blanks the samples that are still in flight
// through the CORDIC pipeline, so SegVld only marks settled samples.
//
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   Start, Abort        : one-cycle control pulses
//   CfgFcw0, CfgStep    : first FCW and per-segment increment (two's compl.)
//   CfgNum, CfgDwell    : segment count / samples per segment (0 means 1)
//   CfgSelXY/CfgSelSign : output selection held for the whole sweep
//   NcoVld              : Vld from the nco
//   En, FCW, selXY, selSign : drive the nco control inputs
//   Busy, Done          : sweep active / one-cycle completion pulse
//   SegVld, SegIdx      : qualified sample strobe and current segment index
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int FCW_W      = nco_pkg::FCW_W,
    parameter int NUM_W      = nco_pkg::NUM_W,
    parameter int DWELL_W    = nco_pkg::DWELL_W,
    parameter int PIPE_DEPTH = nco_pkg::PIPE_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Start,
    input  logic               Abort,
    input  logic [FCW_W-1:0]   CfgFcw0,
    input  logic [FCW_W-1:0]   CfgStep,
    input  logic [NUM_W-1:0]   CfgNum,
    input  logic [DWELL_W-1:0] CfgDwell,
    input  logic               CfgSelXY,
    input  logic               CfgSelSign,
    input  logic               NcoVld,
    output logic               En,
    output logic [FCW_W-1:0]   FCW,
    output logic               selXY,
    output logic               selSign,
    output logic               Busy,
    output logic               Done,
    output logic               SegVld,
    output logic [NUM_W-1:0]   SegIdx
);

    localparam int FLUSH_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(PIPE_DEPTH - 1);

    sweep_state_t       state_q, state_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic [FCW_W-1:0]   step_q, step_d;
    logic [NUM_W-1:0]   seg_idx_q, seg_idx_d;
    logic [NUM_W-1:0]   num_last_q, num_last_d;
    logic [DWELL_W-1:0] dwell_last_q, dwell_last_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic               sel_xy_q, sel_xy_d;
    logic               sel_sign_q, sel_sign_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_dwell_q, in_dwell_d;

    // Next-state logic. The shadow registers store "count - 1" so that the
    // zero-means-one rule is applied once at Start and the terminal tests
    // become plain equality compares.
    always_comb begin
        state_d      = state_q;
        fcw_d        = fcw_q;
        step_d       = step_q;
        seg_idx_d    = seg_idx_q;
        num_last_d   = num_last_q;
        dwell_last_d = dwell_last_q;
        dwell_cnt_d  = dwell_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        sel_xy_d     = sel_xy_q;
        sel_sign_d   = sel_sign_q;

        unique case (state_q)
            IDLE: begin
                // Abort wins over a coincident Start.
                if (Start && !Abort) begin
                    step_d       = CfgStep;
                    num_last_d   = (CfgNum == '0) ? '0 : CfgNum - NUM_W'(1);
                    dwell_last_d = (CfgDwell == '0) ? '0 : CfgDwell - DWELL_W'(1);
                    sel_xy_d     = CfgSelXY;
                    sel_sign_d   = CfgSelSign;
                    fcw_d        = CfgFcw0;
                    seg_idx_d    = '0;
                    flush_cnt_d  = FLUSH_INIT;
                    state_d      = FLUSH;
                end
            end
            FLUSH: begin
                if (Abort) begin
                    state_d = IDLE;
                end else if (flush_cnt_q == '0) begin
                    dwell_cnt_d = '0;
                    state_d     = DWELL;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                end
            end
            DWELL: begin
                if (Abort) begin
                    state_d = IDLE;
                end else if (NcoVld) begin
                    if (dwell_cnt_q == dwell_last_q) begin
                        if (seg_idx_q == num_last_q) begin
                            state_d = DONE;
                        end else begin
                            // Step wraps modulo 2^FCW_W; negative steps come
                            // for free from two's-complement addition.
                            fcw_d       = fcw_q + step_q;
                            seg_idx_d   = seg_idx_q + NUM_W'(1);
                            flush_cnt_d = FLUSH_INIT;
                            state_d     = FLUSH;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so that they come
        // straight out of flops in the same cycle as the state change.
        en_d       = (state_d == FLUSH) || (state_d == DWELL);
        busy_d     = (state_d == FLUSH) || (state_d == DWELL);
        done_d     = (state_d == DONE);
        in_dwell_d = (state_d == DWELL);
    end

    // State and output registers; reset clears everything back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fcw_q        <= '0;
            step_q       <= '0;
            seg_idx_q    <= '0;
            num_last_q   <= '0;
            dwell_last_q <= '0;
            dwell_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            sel_xy_q     <= 1'b0;
            sel_sign_q   <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            in_dwell_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcw_q        <= fcw_d;
            step_q       <= step_d;
            seg_idx_q    <= seg_idx_d;
            num_last_q   <= num_last_d;
            dwell_last_q <= dwell_last_d;
            dwell_cnt_q  <= dwell_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            sel_xy_q     <= sel_xy_d;
            sel_sign_q   <= sel_sign_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            in_dwell_q   <= in_dwell_d;
        end
    end

    // SegVld is the only combinational output: the live NcoVld gated by
    // the registered dwell-window bit.
    assign SegVld  = NcoVld & in_dwell_q;
    assign En      = en_q;
    assign FCW     = fcw_q;
    assign selXY   = sel_xy_q;
    assign selSign = sel_sign_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign SegIdx  = seg_idx_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed, scoreboard-based bench for nco_sweep_ctrl.
// Every sweep pushes the expected (FCW, SegIdx) of each qualified sample.
// Each SegVld pops one entry and checks it; the bench also checks the
// cycle of the Done pulse and the control outputs around Start, Abort
// and reset.
module tb_nco_sweep_ctrl;
    import nco_pkg::*;

    typedef struct {
        logic [FCW_W-1:0] fcw;
        logic [NUM_W-1:0] idx;
    } sample_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start, abort;
    logic [FCW_W-1:0]   cfg_fcw0, cfg_step;
    logic [NUM_W-1:0]   cfg_num;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_sel_xy, cfg_sel_sign;
    logic               nco_vld;
    logic               en;
    logic [FCW_W-1:0]   fcw;
    logic               sel_xy, sel_sign;
    logic               busy, done;
    logic               seg_vld;
    logic [NUM_W-1:0]   seg_idx;

    sample_t sb_q[$];
    int      tests_run    = 0;
    int      tests_failed = 0;
    int      done_cnt     = 0;
    int      n_done;
    int      snap;

    always #5 clk = ~clk;

    nco_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (start),
        .Abort      (abort),
        .CfgFcw0    (cfg_fcw0),
        .CfgStep    (cfg_step),
        .CfgNum     (cfg_num),
        .CfgDwell   (cfg_dwell),
        .CfgSelXY   (cfg_sel_xy),
        .CfgSelSign (cfg_sel_sign),
        .NcoVld     (nco_vld),
        .En         (en),
        .FCW        (fcw),
        .selXY      (sel_xy),
        .selSign    (sel_sign),
        .Busy       (busy),
        .Done       (done),
        .SegVld     (seg_vld),
        .SegIdx     (seg_idx)
    );

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Expected qualified samples of a whole sweep, in order.
    function automatic void pushSweep(input logic [FCW_W-1:0] f0, input logic [FCW_W-1:0] st,
                                      input logic [NUM_W-1:0] num, input logic [DWELL_W-1:0] dw);
        sample_t          s;
        logic [FCW_W-1:0] f;
        int               n_eff;
        int               d_eff;
        f     = f0;
        n_eff = (num == 0) ? 1 : int'(num);
        d_eff = (dw == 0) ? 1 : int'(dw);
        for (int i = 0; i < n_eff; i++) begin
            for (int j = 0; j < d_eff; j++) begin
                s.fcw = f;
                s.idx = NUM_W'(i);
                sb_q.push_back(s);
            end
            f = f + st;
        end
    endfunction

    // Drive one cycle's inputs just after the rising edge, then sample at the
    // falling edge and consume a scoreboard entry for every SegVld.
    task automatic applyStimulus(input logic st, input logic ab, input logic vld);
        sample_t e;
        @(posedge clk);
        #1;
        start   = st;
        abort   = ab;
        nco_vld = vld;
        @(negedge clk);
        if (seg_vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("segvld_unexpected", 32'(seg_vld), 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("sample_fcw", 32'(fcw), 32'(e.fcw));
                checkOutput("sample_segidx", 32'(seg_idx), 32'(e.idx));
            end
            if (nco_vld !== 1'b1)
                checkOutput("segvld_without_ncovld", 32'(seg_vld), 32'd0);
        end
        if (done === 1'b1) done_cnt++;
    endtask

    // Runs one sweep from Start to Done. Cfg inputs are scrambled once
    // the Start has been taken; with poke set, a second Start arrives mid-sweep.
    task automatic doSweep(input logic [FCW_W-1:0] f0, input logic [FCW_W-1:0] st,
                           input logic [NUM_W-1:0] num, input logic [DWELL_W-1:0] dw,
                           input int period, input bit poke, output int n_fin);
        logic vld;
        logic exp_xy;
        logic exp_sign;
        int   done_before;
        cfg_fcw0  = f0;
        cfg_step  = st;
        cfg_num   = num;
        cfg_dwell = dw;
        exp_xy    = cfg_sel_xy;
        exp_sign  = cfg_sel_sign;
        pushSweep(f0, st, num, dw);
        done_before = done_cnt;
        n_fin = 0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int n = 1; n <= 200; n++) begin
            vld = (period <= 1) || ((n % period) == 0);
            if (n == 2) begin
                cfg_fcw0     = ~f0;
                cfg_step     = ~st;
                cfg_num      = num + NUM_W'(3);
                cfg_dwell    = dw + DWELL_W'(7);
                cfg_sel_xy   = ~exp_xy;
                cfg_sel_sign = ~exp_sign;
            end
            applyStimulus(poke && (n == 5), 1'b0, vld);
            if (n == 1) begin
                checkOutput("first_busy", 32'(busy), 32'd1);
                checkOutput("first_en", 32'(en), 32'd1);
                checkOutput("first_fcw", 32'(fcw), 32'(f0));
                checkOutput("first_segidx", 32'(seg_idx), 32'd0);
                checkOutput("first_segvld", 32'(seg_vld), 32'd0);
                checkOutput("sel_xy", 32'(sel_xy), 32'(exp_xy));
                checkOutput("sel_sign", 32'(sel_sign), 32'(exp_sign));
            end
            if (done === 1'b1) begin
                n_fin = n;
                break;
            end
        end
        if (n_fin == 0) begin
            checkOutput("done_timeout", 32'(done), 32'd1);
        end else begin
            checkOutput("done_en", 32'(en), 32'd0);
            checkOutput("done_busy", 32'(busy), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("done_single_pulse", 32'(done), 32'd0);
        checkOutput("done_count", 32'(done_cnt - done_before), 32'd1);
        checkOutput("sel_xy_hold", 32'(sel_xy), 32'(exp_xy));
        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        nco_vld      = 1'b0;
        cfg_fcw0     = '0;
        cfg_step     = '0;
        cfg_num      = '0;
        cfg_dwell    = '0;
        cfg_sel_xy   = 1'b0;
        cfg_sel_sign = 1'b0;

        // Power-on reset values.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_en", 32'(en), 32'd0);
        checkOutput("rst_fcw", 32'(fcw), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_segidx", 32'(seg_idx), 32'd0);
        rst = 1'b0;

        // Basic three-segment sweep: 3*(10+4)+1 cycles to Done.
        cfg_sel_xy   = 1'b1;
        cfg_sel_sign = 1'b0;
        doSweep(20'h01000, 20'h00800, 10'd3, 16'd4, 1, 1'b0, n_done);
        checkOutput("basic_done_cycle", 32'(n_done), 32'd43);

        // FCW wrap on a positive step, then a negative step.
        cfg_sel_xy   = 1'b0;
        cfg_sel_sign = 1'b1;
        doSweep(20'hFFC00, 20'h00800, 10'd2, 16'd1, 1, 1'b0, n_done);
        checkOutput("wrap_done_cycle", 32'(n_done), 32'd23);
        doSweep(20'h00400, 20'hFF800, 10'd2, 16'd1, 1, 1'b0, n_done);
        checkOutput("neg_done_cycle", 32'(n_done), 32'd23);

        // NcoVld every third cycle; the fifth pulse ends each dwell.
        doSweep(20'h02000, 20'h00100, 10'd2, 16'd5, 3, 1'b0, n_done);
        checkOutput("sparse_done_cycle", 32'(n_done), 32'd49);

        // Zero segment count and zero dwell both mean one.
        doSweep(20'h12345, 20'h00010, 10'd0, 16'd0, 1, 1'b0, n_done);
        checkOutput("zero_done_cycle", 32'(n_done), 32'd12);

        // A Start during a sweep is ignored.
        doSweep(20'h01000, 20'h00800, 10'd3, 16'd4, 1, 1'b1, n_done);
        checkOutput("poke_done_cycle", 32'(n_done), 32'd43);

        // Abort in the dwell window of segment 1.
        cfg_sel_xy   = 1'b1;
        cfg_sel_sign = 1'b1;
        cfg_fcw0     = 20'h01000;
        cfg_step     = 20'h00800;
        cfg_num      = 10'd3;
        cfg_dwell    = 16'd4;
        pushSweep(cfg_fcw0, cfg_step, cfg_num, cfg_dwell);
        snap = done_cnt;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int n = 1; n <= 25; n++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_en", 32'(en), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_segvld", 32'(seg_vld), 32'd0);
        checkOutput("abort_segidx_hold", 32'(seg_idx), 32'd1);
        checkOutput("abort_fcw_hold", 32'(fcw), 32'h01800);
        checkOutput("abort_no_done", 32'(done_cnt - snap), 32'd0);
        sb_q.delete();
        applyStimulus(1'b0, 1'b0, 1'b1);
        doSweep(20'h01000, 20'h00800, 10'd3, 16'd4, 1, 1'b0, n_done);
        checkOutput("restart_done_cycle", 32'(n_done), 32'd43);

        // Start together with Abort in IDLE never starts a sweep.
        snap = done_cnt;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("startabort_busy", 32'(busy), 32'd0);
        checkOutput("startabort_en", 32'(en), 32'd0);
        for (int n = 0; n < 15; n++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("startabort_no_done", 32'(done_cnt - snap), 32'd0);

        // Reset held for two cycles in the middle of a sweep.
        cfg_sel_xy   = 1'b1;
        cfg_sel_sign = 1'b1;
        cfg_fcw0     = 20'h01000;
        cfg_step     = 20'h00800;
        cfg_num      = 10'd3;
        cfg_dwell    = 16'd4;
        pushSweep(cfg_fcw0, cfg_step, cfg_num, cfg_dwell);
        snap = done_cnt;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int n = 1; n <= 20; n++) applyStimulus(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("midrst_busy_next", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        checkOutput("midrst_en", 32'(en), 32'd0);
        checkOutput("midrst_fcw", 32'(fcw), 32'd0);
        checkOutput("midrst_sel_xy", 32'(sel_xy), 32'd0);
        checkOutput("midrst_sel_sign", 32'(sel_sign), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_segvld", 32'(seg_vld), 32'd0);
        checkOutput("midrst_segidx", 32'(seg_idx), 32'd0);
        sb_q.delete();
        for (int n = 0; n < 10; n++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("midrst_no_done", 32'(done_cnt - snap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
